imem_loader: RTL and testbench

//  Byte-stream writer for the instruction memory's write side: the core only reads instruction memory.

---
 rtl/imem_loader.sv | 166 ++++++++++++++++
 tb/tb_imem_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream loader for instruction memory; holds the core in reset until the image is written.
// Optional trailing checksum byte: define IMEM_LOADER_CKSUM_EN.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256,
  parameter int          LEN_W     = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] load_len,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             core_reset,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
`ifdef IMEM_LOADER_CKSUM_EN
    S_CKSUM = 3'd3,
`endif
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] word_idx_q;
  logic [LEN_W-1:0] len_q;
  logic [1:0]       byte_idx_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             start_ok;
  logic             load_hs;
  logic             last_word;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]       sum_q;
`endif

  assign start_ok  = start && (state_q == S_IDLE ||
                     state_q == S_DONE || state_q == S_ERR);
  assign load_hs   = byte_valid && (state_q == S_LOAD);
  assign last_word = (word_idx_q + LEN_W'(1)) == len_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          if (load_len == '0)
            state_d = S_DONE;
          else if (load_len > LEN_W'(MAX_WORDS))
            state_d = S_ERR;
          else
            state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (byte_valid && byte_idx_q == 2'd3)
          state_d = S_WRITE;
      end
      S_WRITE: begin
`ifdef IMEM_LOADER_CKSUM_EN
        state_d = last_word ? S_CKSUM : S_LOAD;
`else
        state_d = last_word ? S_DONE : S_LOAD;
`endif
      end
`ifdef IMEM_LOADER_CKSUM_EN
      S_CKSUM: begin
        if (byte_valid)
          state_d = (byte_data == sum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    core_reset = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
      end
`ifdef IMEM_LOADER_CKSUM_EN
      S_CKSUM: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
`endif
      S_DONE: begin
        core_reset = 1'b0;
        done       = 1'b1;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  // Address is captured with the 4th byte so it is stable for the whole WRITE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_idx_q <= '0;
      len_q      <= '0;
      byte_idx_q <= '0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
    end else begin
      if (start_ok) begin
        word_idx_q <= '0;
        byte_idx_q <= '0;
        len_q      <= load_len;
      end
      if (load_hs) begin
        wdata_q[8*byte_idx_q +: 8] <= byte_data;
        byte_idx_q <= byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3)
          addr_q <= BASE_ADDR + 32'({word_idx_q, 2'b00});
      end
      if (state_q == S_WRITE)
        word_idx_q <= word_idx_q + LEN_W'(1);
    end
  end

`ifdef IMEM_LOADER_CKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else if (start_ok) begin
      sum_q <= '0;
    end else if (load_hs) begin
      sum_q <= sum_q + byte_data;
    end
  end
`endif

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected word writes queued as bytes are sent.
// Checksum scenario runs only when IMEM_LOADER_CKSUM_EN is defined.
module tb_imem_loader;

  localparam int MAXW = 256;
  localparam int LW   = 9;

  logic          clk;
  logic          reset;
  logic          start;
  logic [LW-1:0] load_len;
  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          byte_ready;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_reset;
  logic          busy;
  logic          done;
  logic          err;

  imem_loader #(
    .BASE_ADDR(32'h0000_0000),
    .MAX_WORDS(MAXW),
    .LEN_W    (LW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .load_len  (load_len),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_reset(core_reset),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_wr    = 0;
  logic [63:0] exp_q[$];

  logic [7:0] img [8] = '{8'h13, 8'h00, 8'h00, 8'h00,
                          8'h93, 8'h00, 8'h10, 8'h00};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && mem_we) begin
      logic [63:0] e;
      n_wr++;
      chk("we_ready", {31'd0, byte_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexp_we", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("we_addr", mem_addr, e[63:32]);
        chk("we_data", mem_wdata, e[31:0]);
      end
    end
  end

  task automatic pulse_start(input logic [LW-1:0] len);
    start    = 1'b1;
    load_len = len;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("hs_timeout", 32'd0, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic push_img(input int words);
    for (int w = 0; w < words; w++)
      exp_q.push_back({32'(4 * w),
        img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]});
  endtask

  task automatic send_img(input int nbytes, input bit gap);
    for (int i = 0; i < nbytes; i++) send_byte(img[i], gap);
  endtask

  task automatic wait_end();
    int t = 0;
    while (!done && !err && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("end_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int w0;
    reset      = 1'b0;
    start      = 1'b0;
    load_len   = '0;
    byte_data  = '0;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_core", {31'd0, core_reset}, 32'd1);
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    reset = 1'b1;
    byte_valid = 1'b1;
    repeat (10) @(negedge clk);
    byte_valid = 1'b0;
    chk("idle_core", {31'd0, core_reset}, 32'd1);
    chk("idle_flags", {28'd0, byte_ready, mem_we, done, busy}, 32'd0);

    // back-to-back two-word image
    push_img(2);
    pulse_start(LW'(2));
    chk("load_busy", {31'd0, busy}, 32'd1);
    send_img(8, 1'b0);
    wait_end();
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_core", {31'd0, core_reset}, 32'd0);
    chk("t2_nwr", 32'(n_wr), 32'd2);

    // same image with valid toggling
    push_img(2);
    pulse_start(LW'(2));
    chk("t3_core", {31'd0, core_reset}, 32'd1);
    send_img(8, 1'b1);
    wait_end();
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_nwr", 32'(n_wr), 32'd4);
    chk("t3_q", 32'(exp_q.size()), 32'd0);

    // length boundaries
    pulse_start(LW'(MAXW + 1));
    @(negedge clk);
    chk("t4_err", {31'd0, err}, 32'd1);
    chk("t4_core", {31'd0, core_reset}, 32'd1);
    chk("t4_nwr", 32'(n_wr), 32'd4);
    pulse_start(LW'(0));
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_core0", {31'd0, core_reset}, 32'd0);

    // reset mid-load after 6 bytes
    w0 = n_wr;
    push_img(1);
    pulse_start(LW'(2));
    send_img(6, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_nwr", 32'(n_wr - w0), 32'd1);
    chk("t5_core", {31'd0, core_reset}, 32'd1);
    chk("t5_flags", {28'd0, byte_ready, mem_we, busy, done}, 32'd0);
    chk("t5_addr", mem_addr, 32'd0);
    chk("t5_wdata", mem_wdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    push_img(2);
    pulse_start(LW'(2));
    send_img(8, 1'b0);
    wait_end();
    chk("t5_done", {31'd0, done}, 32'd1);
    chk("t5_nwr2", 32'(n_wr - w0), 32'd3);

`ifdef IMEM_LOADER_CKSUM_EN
    push_img(2);
    pulse_start(LW'(2));
    send_img(8, 1'b0);
    send_byte(8'hB6, 1'b0);
    wait_end();
    chk("t6_done", {31'd0, done}, 32'd1);
    push_img(2);
    pulse_start(LW'(2));
    send_img(8, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_end();
    chk("t6_err", {31'd0, err}, 32'd1);
    chk("t6_core", {31'd0, core_reset}, 32'd1);
`endif

    repeat (3) @(negedge clk);
    chk("end_q", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
